// File: rtl/bus_decoder_pkg.sv
// Shared types and widths for the bus source decode path (decoder, encoder, mux).
package bus_decoder_pkg;
  localparam int CODE_W = 5;
  localparam int SEL_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } state_t;
endpackage

// File: rtl/onehot_decoder_5to32.sv
// Combinational binary-to-one-hot decode of a bus source index.
module onehot_decoder_5to32
  import bus_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEL_W-1:0]  onehot
);
  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end
endmodule

// File: rtl/bus_decoder.sv
// Bus-drive sequencer: drives one source for hold+1 cycles, then a one-cycle
// all-off guard so two sources never overlap.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic [CODE_W-1:0] code,
  input  logic [HOLD_W-1:0] hold,
  input  logic              flush,
  output logic              ready,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done
);
  state_t              state, state_d;
  logic [HOLD_W-1:0]   count, count_d;
  logic [CODE_W-1:0]   code_q, dec_code;
  logic [SEL_W-1:0]    dec;
  logic                accept;

  assign ready  = (state == IDLE) && !flush;
  assign accept = req && ready;
  // Decode the live code on the accept edge so sel is valid the very next cycle.
  assign dec_code = accept ? code : code_q;

  onehot_decoder_5to32 u_dec (
    .code   (dec_code),
    .onehot (dec)
  );

  always_comb begin
    state_d = state;
    count_d = count;
    case (state)
      IDLE: if (accept) begin
        state_d = DRIVE;
        count_d = hold;
      end
      DRIVE: begin
        if (flush || count == '0) state_d = GUARD;
        else                      count_d = count - 1'b1;
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      count  <= '0;
      code_q <= '0;
      sel    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      if (accept) code_q <= code;
      sel   <= (state_d == DRIVE) ? dec : '0;
      busy  <= (state_d != IDLE);
      done  <= (state_d == GUARD);
    end
  end
endmodule

// File: tb/tb_bus_decoder.sv
// Directed and randomized checks for bus_decoder drive/guard sequencing.
module tb_bus_decoder;
  import bus_decoder_pkg::*;

  logic              clk = 1'b0;
  logic              clr;
  logic              req;
  logic [CODE_W-1:0] code;
  logic [3:0]        hold;
  logic              flush;
  logic              ready;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              done;

  int total  = 0;
  int passed = 0;

  bus_decoder #(.HOLD_W(4)) dut (
    .clk(clk), .clr(clr), .req(req), .code(code), .hold(hold),
    .flush(flush), .ready(ready), .sel(sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase reference state
  int          mst;
  int          mcnt;
  int          mcode;
  int          accepts;
  int          dones;
  logic [31:0] exp_sel;

  initial begin
    clr = 1'b1; req = 1'b0; code = '0; hold = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    clr = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h1);

    // code=5 hold=2: three drive cycles, then guard
    req = 1'b1; code = 5'd5; hold = 4'd2;
    tick(); req = 1'b0;
    chk("c5_d1", sel, 32'h0000_0020);
    chk("c5_busy", {31'b0, busy}, 32'h1);
    chk("c5_ready_busy", {31'b0, ready}, 32'h0);
    tick(); chk("c5_d2", sel, 32'h0000_0020);
    tick(); chk("c5_d3", sel, 32'h0000_0020);
    tick(); chk("c5_g_sel", sel, 32'h0);
    chk("c5_g_done", {31'b0, done}, 32'h1);
    tick(); chk("c5_idle_done", {31'b0, done}, 32'h0);
    chk("c5_idle_busy", {31'b0, busy}, 32'h0);
    chk("c5_ready", {31'b0, ready}, 32'h1);

    // code=31 / code=0 with hold=0: single drive cycle
    req = 1'b1; code = 5'd31; hold = 4'd0;
    tick(); req = 1'b0;
    chk("c31_d1", sel, 32'h8000_0000);
    tick(); chk("c31_g", sel, 32'h0);
    chk("c31_done", {31'b0, done}, 32'h1);
    tick();
    req = 1'b1; code = 5'd0; hold = 4'd0;
    tick(); req = 1'b0;
    chk("c0_d1", sel, 32'h0000_0001);
    tick(); chk("c0_g", sel, 32'h0);
    chk("c0_done", {31'b0, done}, 32'h1);
    tick();

    // code=9 hold=15 with flush in the second drive cycle
    req = 1'b1; code = 5'd9; hold = 4'd15;
    tick(); req = 1'b0;
    chk("c9_d1", sel, 32'h0000_0200);
    tick(); chk("c9_d2", sel, 32'h0000_0200);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("c9_g_sel", sel, 32'h0);
    chk("c9_g_done", {31'b0, done}, 32'h1);
    tick(); chk("c9_idle_busy", {31'b0, busy}, 32'h0);

    // flush in IDLE blocks acceptance only
    req = 1'b1; code = 5'd4; flush = 1'b1;
    #1; chk("fl_ready", {31'b0, ready}, 32'h0);
    tick(); req = 1'b0; flush = 1'b0;
    chk("fl_sel", sel, 32'h0);
    chk("fl_busy", {31'b0, busy}, 32'h0);
    chk("fl_done", {31'b0, done}, 32'h0);

    // req held with hold=1: accepts every 4 cycles, code change while busy ignored
    req = 1'b1; code = 5'd3; hold = 4'd1;
    tick(); code = 5'd7;
    chk("bb_a_d1", sel, 32'h0000_0008);
    tick(); chk("bb_a_d2", sel, 32'h0000_0008);
    tick(); chk("bb_a_g", sel, 32'h0);
    chk("bb_a_done", {31'b0, done}, 32'h1);
    tick(); chk("bb_idle_sel", sel, 32'h0);
    chk("bb_idle_ready", {31'b0, ready}, 32'h1);
    tick(); req = 1'b0;
    chk("bb_b_d1", sel, 32'h0000_0080);
    tick(); chk("bb_b_d2", sel, 32'h0000_0080);
    tick(); chk("bb_b_done", {31'b0, done}, 32'h1);
    tick();

    // async clr mid-drive
    req = 1'b1; code = 5'd12; hold = 4'd5;
    tick(); req = 1'b0;
    chk("cl_d1", sel, 32'h0000_1000);
    tick();
    #2 clr = 1'b1;
    #1;
    chk("cl_async_sel", sel, 32'h0);
    chk("cl_async_busy", {31'b0, busy}, 32'h0);
    clr = 1'b0;
    tick(); chk("cl_no_done", {31'b0, done}, 32'h0);
    chk("cl_ready", {31'b0, ready}, 32'h1);
    req = 1'b1; code = 5'd2; hold = 4'd0;
    tick(); req = 1'b0;
    chk("cl_next_d1", sel, 32'h0000_0004);
    tick(); chk("cl_next_done", {31'b0, done}, 32'h1);
    tick();

    // randomized run against a behavioral reference
    mst = 0; mcnt = 0; mcode = 0; accepts = 0; dones = 0;
    for (int i = 0; i < 10000; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      code  = 5'($urandom_range(0, 31));
      hold  = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 7) == 0);
      case (mst)
        0: if (req && !flush) begin
          mst = 1; mcnt = int'(hold); mcode = int'(code); accepts++;
        end
        1: if (flush || mcnt == 0) mst = 2; else mcnt--;
        default: mst = 0;
      endcase
      exp_sel = (mst == 1) ? (32'h1 << mcode) : 32'h0;
      tick();
      if (done) dones++;
      chk("rnd_onehot0", {31'b0, $onehot0(sel)}, 32'h1);
      chk("rnd_sel", sel, exp_sel);
      if (!busy) chk("rnd_idle_sel", sel, 32'h0);
    end
    req = 1'b0; flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    chk("rnd_done_count", dones, accepts);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
